// File: rtl/motor_speed_ramp_pkg.sv
// Shared state encoding and duty limits for the motor speed ramp.
// Pure declarations; no timing or flow-control behaviour of its own.
package motor_pkg;
    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN,
        REVERSE,
        ESTOP
    } state_t;

    localparam int   PWM_MAX = 127;
    localparam logic FWD     = 1'b1;
endpackage

// File: rtl/motor_speed_ramp_step_tick_gen.sv
// Free-running ramp pacer: counts 0..STEP_CYCLES-1, tick high for the wrap cycle.
// Tick follows the counter register combinationally; no backpressure, never stalls.
module step_tick_gen #(
    parameter int STEP_CYCLES = 3125
) (
    input  logic clk_3125KHz,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);
endmodule

// File: rtl/motor_speed_ramp.sv
// Slew-limits motor duty/direction commands; outputs registered, one step per tick.
// cmd_ready drops during REVERSE and ESTOP; estop blocks acceptance and zeroes duty on the next edge.
module motor_speed_ramp
    import motor_pkg::*;
#(
    parameter int STEP_CYCLES = 3125,
    parameter int STEP_SIZE   = 4,
    parameter int MAX_DUTY    = PWM_MAX
) (
    input  logic       clk_3125KHz,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_speed,
    input  logic       cmd_dir,
    input  logic       estop,
    output logic [7:0] pulse_width,
    output logic       motor_dir,
    output logic       at_target
);
    localparam logic [7:0] STEP = 8'(STEP_SIZE);
    localparam logic [7:0] DMAX = 8'(MAX_DUTY);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_pw, w_pw_nxt;
    logic [7:0] r_target, w_target_nxt;
    logic       r_dir, w_dir_nxt;
    logic       r_tdir, w_tdir_nxt;
    logic       r_cmd_ready, r_at_target;

    logic       w_tick, w_accept;
    logic [7:0] w_cmd_clamped, w_diff_up, w_diff_dn, w_inc, w_dec, w_dec0;

    step_tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_step_tick_gen (
        .clk_3125KHz (clk_3125KHz),
        .rst_n       (rst_n),
        .tick        (w_tick)
    );

    assign w_accept      = cmd_valid && r_cmd_ready && !estop;
    assign w_cmd_clamped = (cmd_speed > DMAX) ? DMAX : cmd_speed;

    // Order is checked before subtracting so the 8-bit differences never wrap.
    assign w_diff_up = (r_target > r_pw) ? (r_target - r_pw) : 8'd0;
    assign w_diff_dn = (r_pw > r_target) ? (r_pw - r_target) : 8'd0;
    assign w_inc     = (w_diff_up > STEP) ? STEP : w_diff_up;
    assign w_dec     = (w_diff_dn > STEP) ? STEP : w_diff_dn;
    assign w_dec0    = (r_pw > STEP) ? STEP : r_pw;

    always_comb begin
        w_state_nxt  = r_state;
        w_pw_nxt     = r_pw;
        w_dir_nxt    = r_dir;
        w_target_nxt = r_target;
        w_tdir_nxt   = r_tdir;

        if (w_accept) begin
            w_target_nxt = w_cmd_clamped;
            w_tdir_nxt   = cmd_dir;
        end

        if (estop) begin
            w_state_nxt  = ESTOP;
            w_pw_nxt     = 8'd0;
            w_target_nxt = 8'd0;
            w_tdir_nxt   = r_dir;
        end else begin
            case (r_state)
                IDLE, RAMP_UP, RAMP_DOWN: begin
                    if (r_tdir != r_dir) begin
                        if (r_pw != 8'd0) begin
                            w_state_nxt = REVERSE;
                        end else begin
                            w_dir_nxt   = r_tdir;
                            w_state_nxt = (r_target != 8'd0) ? RAMP_UP : IDLE;
                        end
                    end else if (r_target > r_pw) begin
                        w_state_nxt = RAMP_UP;
                        if (w_tick && (r_state == RAMP_UP)) begin
                            w_pw_nxt = r_pw + w_inc;
                            if (w_inc == w_diff_up) w_state_nxt = IDLE;
                        end
                    end else if (r_target < r_pw) begin
                        w_state_nxt = RAMP_DOWN;
                        if (w_tick && (r_state == RAMP_DOWN)) begin
                            w_pw_nxt = r_pw - w_dec;
                            if (w_dec == w_diff_dn) w_state_nxt = IDLE;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                REVERSE: begin
                    // Direction only changes once duty has sat at zero for a cycle.
                    if (r_pw == 8'd0) begin
                        w_dir_nxt   = r_tdir;
                        w_state_nxt = (r_target != 8'd0) ? RAMP_UP : IDLE;
                    end else if (w_tick) begin
                        w_pw_nxt = r_pw - w_dec0;
                    end
                end
                ESTOP:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pw        <= 8'd0;
            r_dir       <= FWD;
            r_target    <= 8'd0;
            r_tdir      <= FWD;
            r_cmd_ready <= 1'b1;
            r_at_target <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_pw        <= w_pw_nxt;
            r_dir       <= w_dir_nxt;
            r_target    <= w_target_nxt;
            r_tdir      <= w_tdir_nxt;
            r_cmd_ready <= (w_state_nxt != REVERSE) && (w_state_nxt != ESTOP);
            r_at_target <= (w_pw_nxt == w_target_nxt) && (w_dir_nxt == w_tdir_nxt)
                           && (w_state_nxt == IDLE);
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign pulse_width = r_pw;
    assign motor_dir   = r_dir;
    assign at_target   = r_at_target;
endmodule
